btb_renew_arbiter: RTL and testbench

- Shares the single BTB write port among the three decode slots.
- The decoder can raise up to three BTB-renew requests per cycle, each carrying pc_decode / pc_branch.
- This block compacts each request group in slot order into an in-order queue and drains one entry per cycle to the BTB.
- It back-pressures decode when the queue cannot absorb a full group, and discards everything on a pipeline flush.

---
 rtl/btb_renew_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_btb_renew_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_renew_arbiter.sv
// ============================================================================
// btb_renew_arbiter
//
// Purpose:
//   The BTB has a single write port. The decoder has three slots, and each
//   slot can ask to renew a BTB entry in the same cycle. This block collects
//   each request group, packs the set slots in slot order into an in-order
//   queue, and drains one entry per cycle into the BTB write port.
//   It throttles decode whenever the queue cannot take a full group of three.
//   A pipeline flush discards all queued work.
//
// Parameters:
//   DEPTH  - queue entries; must be a power of two and at least 4
//   PTR_W  - pointer width, derived as $clog2(DEPTH)
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   flush          in   mispredict/exception flush, empties the queue
//   renew_en       in   [2:0]  per-slot renew request, bit i = slot i
//   renew_pc       in   [95:0] slot i pc_decode at [32i+31:32i]
//   renew_target   in   [95:0] slot i pc_branch at [32i+31:32i]
//   renew_ready    out  group accepted this cycle (needs >= 3 free entries)
//   btb_wr_en      out  head entry valid toward the BTB
//   btb_wr_pc      out  [31:0] head pc
//   btb_wr_target  out  [31:0] head target
//   btb_wr_ready   in   BTB takes the head entry this cycle
//   count          out  [PTR_W:0] occupied entries
//   dedup_drop_cnt out  [15:0] saturating count of dropped duplicate slots
//                       (present only with BTB_RENEW_DEDUP_EN)
//
// Build option:
//   BTB_RENEW_DEDUP_EN - when defined, a slot is dropped if its pc matches
//   either a lower-numbered set slot of the same group or the newest entry
//   still resident in the queue. The first occurrence keeps its target.
//   When undefined, every set slot is queued.
// ============================================================================
module btb_renew_arbiter #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [2:0]       renew_en,
    input  logic [95:0]      renew_pc,
    input  logic [95:0]      renew_target,
    output logic             renew_ready,
    output logic             btb_wr_en,
    output logic [31:0]      btb_wr_pc,
    output logic [31:0]      btb_wr_target,
    input  logic             btb_wr_ready,
    output logic [PTR_W:0]   count
`ifdef BTB_RENEW_DEDUP_EN
    ,
    output logic [15:0]      dedup_drop_cnt
`endif
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] GROUP_C = (PTR_W + 1)'(3);

    // Queue storage. It is deliberately not reset: count alone decides
    // which entries are meaningful.
    logic [31:0]      mem_pc  [DEPTH];
    logic [31:0]      mem_tgt [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic [PTR_W:0]   free_slots;
    logic             pop;
    logic             accept;
    logic [2:0]       keep;
    logic [1:0]       n_enq;
    logic [1:0]       n_push;
    logic [PTR_W-1:0] wr_idx [3];

    // ------------------------------------------------------------------
    // Admission and drain handshakes.
    // renew_ready depends only on count, never on renew_en. Decode can
    // therefore hold a group without a combinational loop through this
    // block. Requiring room for a full group means a group is never split.
    // ------------------------------------------------------------------
    assign free_slots    = DEPTH_C - count;
    assign renew_ready   = (free_slots >= GROUP_C);
    assign btb_wr_en     = (count != '0) && !flush;
    assign btb_wr_pc     = mem_pc[head];
    assign btb_wr_target = mem_tgt[head];
    assign pop           = btb_wr_en && btb_wr_ready;
    assign accept        = renew_ready && (|renew_en) && !flush;

`ifdef BTB_RENEW_DEDUP_EN
    // ------------------------------------------------------------------
    // Duplicate filtering.
    // A slot is dropped when its pc matches a lower-numbered set slot in
    // the same group. Matching against set slots, not kept ones, means a
    // chain of equal pcs keeps only the first occurrence.
    // A slot is also dropped when it matches the newest queued entry.
    // That entry only counts if it survives this cycle's pop, which can
    // remove it only when it is the sole occupant.
    // ------------------------------------------------------------------
    logic [31:0] last_pc;
    logic        last_resident;
    logic [2:0]  dup;
    logic [1:0]  n_drop;

    assign last_pc       = mem_pc[tail - PTR_W'(1)];
    assign last_resident = (count != '0) && !(pop && (count == (PTR_W + 1)'(1)));

    always_comb begin
        dup = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < i; j++) begin
                if (renew_en[j] && (renew_pc[32*j +: 32] == renew_pc[32*i +: 32])) begin
                    dup[i] = 1'b1;
                end
            end
            if (last_resident && (last_pc == renew_pc[32*i +: 32])) begin
                dup[i] = 1'b1;
            end
        end
    end

    assign keep = renew_en & ~dup;

    // Drops are counted only when the group is actually taken. A rejected
    // group is presented again later and would otherwise be counted twice.
    always_comb begin
        n_drop = 2'd0;
        if (accept) begin
            n_drop = {1'b0, renew_en[0] & dup[0]}
                   + {1'b0, renew_en[1] & dup[1]}
                   + {1'b0, renew_en[2] & dup[2]};
        end
    end

    // Saturating drop counter. Only rst_n clears it; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dedup_drop_cnt <= '0;
        end else if (({1'b0, dedup_drop_cnt} + 17'(n_drop)) > 17'h0_FFFF) begin
            dedup_drop_cnt <= 16'hFFFF;
        end else begin
            dedup_drop_cnt <= dedup_drop_cnt + 16'(n_drop);
        end
    end
`else
    assign keep = renew_en;
`endif

    // ------------------------------------------------------------------
    // Compaction.
    // Each kept slot lands at tail plus the number of kept slots below it.
    // This packs a sparse group such as 3'b101 into consecutive entries.
    // ------------------------------------------------------------------
    assign n_enq  = {1'b0, keep[0]} + {1'b0, keep[1]} + {1'b0, keep[2]};
    assign n_push = accept ? n_enq : 2'd0;

    always_comb begin
        wr_idx[0] = tail;
        wr_idx[1] = tail + PTR_W'(keep[0]);
        wr_idx[2] = tail + PTR_W'({1'b0, keep[0]} + {1'b0, keep[1]});
    end

    // Storage write. A new entry only becomes visible at the head on the
    // next cycle, so there is no bypass from renew_* to btb_wr_*.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                if (keep[i]) begin
                    mem_pc[wr_idx[i]]  <= renew_pc[32*i +: 32];
                    mem_tgt[wr_idx[i]] <= renew_target[32*i +: 32];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer and occupancy update.
    // Pointers wrap naturally because DEPTH is a power of two.
    // Flush wins over any push or pop in the same cycle. Both are already
    // gated by flush, and the pointers return to zero so stale storage
    // can never reappear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(n_push);
            count <= count + (PTR_W + 1)'(n_push) - (PTR_W + 1)'(pop);
        end
    end

endmodule

// File: tb/tb_btb_renew_arbiter.sv
// ============================================================================
// tb_btb_renew_arbiter
//
// Scoreboard bench for btb_renew_arbiter. The stimulus process decides
// whether each group is accepted, using occupancy and queue rules. It pushes
// the expected BTB writes into a queue. A separate monitor compares the DUT
// handshakes and head data against that queue and pops on every write.
// Build with BTB_RENEW_DEDUP_EN to also exercise duplicate dropping.
// ============================================================================
module tb_btb_renew_arbiter;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [2:0]  renew_en;
    logic [95:0] renew_pc;
    logic [95:0] renew_target;
    logic        renew_ready;
    logic        btb_wr_en;
    logic [31:0] btb_wr_pc;
    logic [31:0] btb_wr_target;
    logic        btb_wr_ready;
    logic [3:0]  count;
`ifdef BTB_RENEW_DEDUP_EN
    logic [15:0] dedup_drop_cnt;
`endif

    entry_t sb[$];
    int     checks = 0;
    int     errors = 0;
    int     pre_size = 0;
    int     model_drops = 0;

    always #5 clk = ~clk;

    btb_renew_arbiter #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .renew_en      (renew_en),
        .renew_pc      (renew_pc),
        .renew_target  (renew_target),
        .renew_ready   (renew_ready),
        .btb_wr_en     (btb_wr_en),
        .btb_wr_pc     (btb_wr_pc),
        .btb_wr_target (btb_wr_target),
        .btb_wr_ready  (btb_wr_ready),
        .count         (count)
`ifdef BTB_RENEW_DEDUP_EN
        ,
        .dedup_drop_cnt(dedup_drop_cnt)
`endif
    );

    // Single comparison point: every check goes through here.
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at negedge+2.
    // The expected queue is updated from the queue rules alone:
    // a group is taken when no flush is active, at least 3 entries are
    // free, and at least one slot is set.
    task automatic apply_stimulus(input logic [2:0] en, input logic [95:0] pcs,
                                  input logic [95:0] tgts, input logic rdy,
                                  input logic fl, output logic acc);
        int   sz;
        int   will_pop;
        logic drop;
        logic [31:0] p;
        entry_t e;
        @(negedge clk);
        #2;
        flush        = fl;
        renew_en     = en;
        renew_pc     = pcs;
        renew_target = tgts;
        btb_wr_ready = rdy;
        sz       = sb.size();
        pre_size = sz;
        will_pop = (sz != 0 && !fl && rdy) ? 1 : 0;
        acc = !fl && ((DEPTH - sz) >= 3) && (en != 3'b000);
        if (acc) begin
            for (int i = 0; i < 3; i++) begin
                if (en[i]) begin
                    p    = pcs[32*i +: 32];
                    drop = 1'b0;
`ifdef BTB_RENEW_DEDUP_EN
                    for (int j = 0; j < i; j++) begin
                        if (en[j] && pcs[32*j +: 32] == p) drop = 1'b1;
                    end
                    if ((sz - will_pop) > 0 && sb[sz-1].pc == p) drop = 1'b1;
`endif
                    if (drop) begin
                        if (model_drops < 65535) model_drops++;
                    end else begin
                        e.pc  = p;
                        e.tgt = tgts[32*i +: 32];
                        sb.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        repeat (n) apply_stimulus(3'b000, 96'd0, 96'd0, rdy, 1'b0, acc);
    endtask

    // Assert reset mid-cycle, away from any clock edge, then release it a
    // cycle later.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n        = 1'b0;
        flush        = 1'b0;
        renew_en     = 3'b000;
        btb_wr_ready = 1'b0;
        pre_size     = 0;
        model_drops  = 0;
        @(negedge clk);
        #2;
        rst_n    = 1'b1;
        pre_size = 0;
    endtask

    // Monitor: checks occupancy at negedge+1 and the write handshake at
    // negedge+3. Both points sit well away from the rising edge.
    always @(negedge clk) begin
        logic exp_en;
        #1;
        if (rst_n) begin
            check_output("count", 64'(count), 64'(sb.size()));
            check_output("renew_ready", 64'(renew_ready), 64'((DEPTH - sb.size()) >= 3));
`ifdef BTB_RENEW_DEDUP_EN
            check_output("dedup_drop_cnt", 64'(dedup_drop_cnt), 64'(model_drops));
`endif
        end
        #2;
        if (!rst_n) begin
            check_output("reset_count", 64'(count), 64'd0);
            check_output("reset_wr_en", 64'(btb_wr_en), 64'd0);
            check_output("reset_renew_ready", 64'(renew_ready), 64'd1);
            sb.delete();
        end else begin
            exp_en = (pre_size != 0) && !flush;
            check_output("btb_wr_en", 64'(btb_wr_en), 64'(exp_en));
            if (exp_en && btb_wr_ready) begin
                check_output("btb_wr_pc", 64'(btb_wr_pc), 64'(sb[0].pc));
                check_output("btb_wr_target", 64'(btb_wr_target), 64'(sb[0].tgt));
                void'(sb.pop_front());
            end
            if (flush) sb.delete();
        end
    end

    initial begin
        logic        acc;
        logic [2:0]  g_en;
        logic [95:0] g_pc;
        logic [95:0] g_tg;
        logic        have;
        logic        rdy;
        logic        fl;
        rst_n        = 1'b0;
        flush        = 1'b0;
        renew_en     = 3'b000;
        renew_pc     = '0;
        renew_target = '0;
        btb_wr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        $display("[TB] full group drain");
        apply_stimulus(3'b111, {32'h108, 32'h104, 32'h100},
                       {32'hA008, 32'hA004, 32'hA000}, 1'b1, 1'b0, acc);
        idle(4, 1'b1);

        $display("[TB] sparse group");
        apply_stimulus(3'b101, {32'h208, 32'h204, 32'h200},
                       {32'hB008, 32'hB004, 32'hB000}, 1'b1, 1'b0, acc);
        idle(3, 1'b1);

        $display("[TB] backpressure");
        apply_stimulus(3'b111, {32'h318, 32'h314, 32'h310}, {32'hC2, 32'hC1, 32'hC0}, 1'b0, 1'b0, acc);
        apply_stimulus(3'b111, {32'h324, 32'h320, 32'h31C}, {32'hC5, 32'hC4, 32'hC3}, 1'b0, 1'b0, acc);
        apply_stimulus(3'b111, {32'h330, 32'h32C, 32'h328}, {32'hC8, 32'hC7, 32'hC6}, 1'b0, 1'b0, acc);
        apply_stimulus(3'b111, {32'h330, 32'h32C, 32'h328}, {32'hC8, 32'hC7, 32'hC6}, 1'b1, 1'b0, acc);
        apply_stimulus(3'b111, {32'h330, 32'h32C, 32'h328}, {32'hC8, 32'hC7, 32'hC6}, 1'b0, 1'b0, acc);
        idle(1, 1'b0);
        idle(9, 1'b1);

        $display("[TB] wrap-around stream");
        for (int k = 0; k < 20; k++) begin
            g_en = 3'b001 << $urandom_range(0, 2);
            apply_stimulus(g_en, {3{32'h400 + 32'(4 * k)}}, {3{32'hD000 + 32'(k)}}, 1'b1, 1'b0, acc);
        end
        idle(3, 1'b1);

        $display("[TB] flush with pending group");
        apply_stimulus(3'b111, {32'h508, 32'h504, 32'h500}, {32'hE2, 32'hE1, 32'hE0}, 1'b0, 1'b0, acc);
        apply_stimulus(3'b011, {32'h514, 32'h510, 32'h50C}, {32'hE5, 32'hE4, 32'hE3}, 1'b0, 1'b0, acc);
        apply_stimulus(3'b011, {32'h520, 32'h51C, 32'h518}, {32'hE8, 32'hE7, 32'hE6}, 1'b1, 1'b1, acc);
        idle(4, 1'b1);

        $display("[TB] async reset mid-drain");
        apply_stimulus(3'b111, {32'h608, 32'h604, 32'h600}, {32'hF2, 32'hF1, 32'hF0}, 1'b0, 1'b0, acc);
        apply_stimulus(3'b111, {32'h614, 32'h610, 32'h60C}, {32'hF5, 32'hF4, 32'hF3}, 1'b0, 1'b0, acc);
        idle(2, 1'b1);
        do_reset();
        idle(2, 1'b1);

`ifdef BTB_RENEW_DEDUP_EN
        $display("[TB] duplicate group");
        apply_stimulus(3'b111, {32'h304, 32'h300, 32'h300}, {32'h77, 32'h66, 32'h55}, 1'b0, 1'b0, acc);
        idle(1, 1'b0);
        idle(3, 1'b1);
`endif

        $display("[TB] random traffic");
        have = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!have) begin
                g_en = 3'($urandom_range(0, 7));
                for (int k = 0; k < 3; k++) begin
                    g_pc[32*k +: 32] = 32'h1000 + 32'(4 * $urandom_range(0, 5));
                    g_tg[32*k +: 32] = $urandom;
                end
                have = 1'b1;
            end
            rdy = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 39) == 0);
            apply_stimulus(g_en, g_pc, g_tg, rdy, fl, acc);
            if (acc || fl || g_en == 3'b000) have = 1'b0;
        end
        idle(12, 1'b1);

        @(negedge clk);
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
